// File: rtl/alu_set_pkg.sv
// Shared opcode encodings and select width for the ALU constant/bit-set datapath.
package alu_set_pkg;

    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] OP_CLR        = 4'b0000;
    localparam logic [SEL_W-1:0] OP_PASS_A     = 4'b0001;
    localparam logic [SEL_W-1:0] OP_PASS_B     = 4'b0010;
    localparam logic [SEL_W-1:0] OP_BSET       = 4'b0011;
    localparam logic [SEL_W-1:0] OP_BCLR       = 4'b0100;
    localparam logic [SEL_W-1:0] OP_BTGL       = 4'b0101;
    localparam logic [SEL_W-1:0] OP_ACC_OR     = 4'b0110;
    localparam logic [SEL_W-1:0] OP_ACC_RD_CLR = 4'b0111;
    localparam logic [SEL_W-1:0] OP_SET        = 4'b1111;

endpackage

// File: rtl/set_bit_mask.sv
// One-hot bit mask from a bit index, with a flag for indices beyond the datapath width.
module set_bit_mask #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] mask_o,
    output logic             idx_oob_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (32'(idx_i) == i) begin
                mask_o[i] = 1'b1;
            end
        end
        idx_oob_o = (32'(idx_i) >= WIDTH);
    end

endmodule

// File: rtl/alu_set_unit.sv
// Registered constant/pass/bit-op/accumulator unit behind a valid/ready handshake.
// Optional err output and held-result on illegal opcodes when ALU_SET_ERR_EN is defined.
module alu_set_unit
    import alu_set_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_Set,
    input  logic [WIDTH-1:0] B_Set,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X_Set,
    output logic [WIDTH-1:0] acc_out
`ifdef ALU_SET_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] mask;
    logic             idx_oob;
    logic             illegal;
    logic             accept;

    set_bit_mask #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_set_bit_mask (
        .idx_i     (B_Set[IDX_W-1:0]),
        .mask_o    (mask),
        .idx_oob_o (idx_oob)
    );

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign X_Set     = x_q;
    assign acc_out   = acc_q;

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        acc_d   = acc_q;
        unique case (sel)
            OP_CLR:    res = '0;
            OP_SET:    res = '1;
            OP_PASS_A: res = A_Set;
            OP_PASS_B: res = B_Set;
            OP_BSET: begin
                res     = idx_oob ? A_Set : (A_Set | mask);
                illegal = idx_oob;
            end
            OP_BCLR: begin
                res     = idx_oob ? A_Set : (A_Set & ~mask);
                illegal = idx_oob;
            end
            OP_BTGL: begin
                res     = idx_oob ? A_Set : (A_Set ^ mask);
                illegal = idx_oob;
            end
            // Accumulator only moves on an accepted request, never on a stalled one.
            OP_ACC_OR: begin
                res = acc_q | A_Set;
                if (accept) acc_d = acc_q | A_Set;
            end
            OP_ACC_RD_CLR: begin
                res = acc_q;
                if (accept) acc_d = '0;
            end
            default: begin
                illegal = 1'b1;
`ifdef ALU_SET_ERR_EN
                res = x_q;
`else
                res = '0;
`endif
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        if (accept) begin
            valid_d = 1'b1;
            x_d     = res;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef ALU_SET_ERR_EN
    logic err_q, err_d;

    assign err_d = accept ? illegal : err_q;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_set_unit.sv
// Self-checking bench for alu_set_unit (WIDTH=6) using an expected-result queue.
module tb_alu_set_unit;
    import alu_set_pkg::*;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_Set;
    logic [W-1:0] B_Set;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] X_Set;
    logic [W-1:0] acc_out;
`ifdef ALU_SET_ERR_EN
    logic         err;
`endif

    typedef struct packed {
        logic [W-1:0] x;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   asserts = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    alu_set_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_Set     (A_Set),
        .B_Set     (B_Set),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X_Set     (X_Set),
        .acc_out   (acc_out)
`ifdef ALU_SET_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = v;
        sel      = op;
        A_Set    = a;
        B_Set    = b;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'b0000, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        asserts++;
        if (X_Set !== 6'b000000) begin
            fails++; $display("FAIL reset_x: got %b want 000000", X_Set);
        end
        asserts++;
        if (acc_out !== 6'b000000) begin
            fails++; $display("FAIL reset_acc: got %b want 000000", acc_out);
        end
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // CLR then SET back-to-back; operands nonzero so constants must ignore them.
    task automatic test_const;
        logic [3:0]   ops[2];
        logic [W-1:0] xs[2];
        ops = '{OP_CLR, OP_SET};
        xs  = '{6'b000000, 6'b111111};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ops[i], 6'b101010, 6'b010101);
            exp_q.push_back('{x: xs[i], e: 1'b0});
            @(negedge clk);
            asserts++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                fails++; $display("FAIL const_valid[%0d]: got %b want 1", i, out_valid);
            end else begin
                asserts++;
                if (X_Set !== exp_q[0].x) begin
                    fails++; $display("FAIL const_x[%0d]: got %b want %b", i, X_Set, exp_q[0].x);
                end
                void'(exp_q.pop_front());
            end
        end
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL const_drop: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_bitops;
        logic [3:0]   ops[5];
        logic [W-1:0] as[5];
        logic [W-1:0] bs[5];
        logic [W-1:0] xs[5];
        ops = '{OP_BSET, OP_BCLR, OP_BTGL, OP_PASS_B, OP_PASS_A};
        as  = '{6'b101010, 6'b101010, 6'b101010, 6'b000000, 6'b011001};
        bs  = '{6'b111000, 6'b110001, 6'b000101, 6'b110110, 6'b100100};
        xs  = '{6'b101011, 6'b101000, 6'b001010, 6'b110110, 6'b011001};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            exp_q.push_back('{x: xs[i], e: 1'b0});
            @(negedge clk);
            asserts++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                fails++; $display("FAIL bitop_valid[%0d]: got %b want 1", i, out_valid);
            end else begin
                asserts++;
                if (X_Set !== exp_q[0].x) begin
                    fails++; $display("FAIL bitop_x[%0d]: got %b want %b", i, X_Set, exp_q[0].x);
                end
`ifdef ALU_SET_ERR_EN
                asserts++;
                if (err !== exp_q[0].e) begin
                    fails++; $display("FAIL bitop_err[%0d]: got %b want %b", i, err, exp_q[0].e);
                end
`endif
                void'(exp_q.pop_front());
            end
        end
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_acc;
        logic [3:0]   ops[3];
        logic [W-1:0] as[3];
        logic [W-1:0] xs[3];
        logic [W-1:0] accs[3];
        ops  = '{OP_ACC_OR, OP_ACC_OR, OP_ACC_RD_CLR};
        as   = '{6'b000011, 6'b110000, 6'b111111};
        xs   = '{6'b000011, 6'b110011, 6'b110011};
        accs = '{6'b000011, 6'b110011, 6'b000000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], as[i], 6'b000000);
            exp_q.push_back('{x: xs[i], e: 1'b0});
            @(negedge clk);
            asserts++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                fails++; $display("FAIL acc_valid[%0d]: got %b want 1", i, out_valid);
            end else begin
                asserts++;
                if (X_Set !== exp_q[0].x) begin
                    fails++; $display("FAIL acc_x[%0d]: got %b want %b", i, X_Set, exp_q[0].x);
                end
                void'(exp_q.pop_front());
            end
            asserts++;
            if (acc_out !== accs[i]) begin
                fails++; $display("FAIL acc_out[%0d]: got %b want %b", i, acc_out, accs[i]);
            end
        end
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
    endtask

    // Consumer stalls 3 cycles; a pending ACC_OR must not touch acc until accepted.
    task automatic test_stall;
        out_ready = 1'b0;
        drive(1'b1, OP_PASS_A, 6'b010101, 6'b000000);
        exp_q.push_back('{x: 6'b010101, e: 1'b0});
        @(negedge clk);
        drive(1'b1, OP_ACC_OR, 6'b000111, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            asserts++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                fails++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid);
            end else begin
                asserts++;
                if (X_Set !== exp_q[0].x) begin
                    fails++; $display("FAIL stall_x[%0d]: got %b want %b", i, X_Set, exp_q[0].x);
                end
            end
            asserts++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            asserts++;
            if (acc_out !== 6'b000000) begin
                fails++; $display("FAIL stall_acc[%0d]: got %b want 000000", i, acc_out);
            end
        end
        out_ready = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release: in_ready got %b want 1", in_ready);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back('{x: 6'b000111, e: 1'b0});
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || X_Set !== exp_q[0].x) begin
            fails++; $display("FAIL stall_acc_result: got %b valid %b want 000111", X_Set, out_valid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        asserts++;
        if (acc_out !== 6'b000111) begin
            fails++; $display("FAIL stall_acc_after: got %b want 000111", acc_out);
        end
        drive(1'b1, OP_ACC_RD_CLR, 6'b000000, 6'b000000);
        exp_q.push_back('{x: 6'b000111, e: 1'b0});
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || X_Set !== exp_q[0].x) begin
            fails++; $display("FAIL stall_rdclr: got %b valid %b want 000111", X_Set, out_valid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0 || acc_out !== 6'b000000) begin
            fails++; $display("FAIL stall_drain: valid %b acc %b want 0 000000", out_valid, acc_out);
        end
    endtask

    task automatic test_oob;
        logic [3:0]   ops[4];
        logic [W-1:0] as[4];
        logic [W-1:0] bs[4];
        logic [W-1:0] xs[4];
        logic         es[4];
        ops = '{OP_BSET, OP_BTGL, 4'b1010, OP_CLR};
        as  = '{6'b000001, 6'b100000, 6'b111111, 6'b111111};
        bs  = '{6'b000111, 6'b000110, 6'b000000, 6'b000000};
`ifdef ALU_SET_ERR_EN
        xs  = '{6'b000001, 6'b100000, 6'b100000, 6'b000000};
`else
        xs  = '{6'b000001, 6'b100000, 6'b000000, 6'b000000};
`endif
        es  = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            exp_q.push_back('{x: xs[i], e: es[i]});
            @(negedge clk);
            asserts++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                fails++; $display("FAIL oob_valid[%0d]: got %b want 1", i, out_valid);
            end else begin
                asserts++;
                if (X_Set !== exp_q[0].x) begin
                    fails++; $display("FAIL oob_x[%0d]: got %b want %b", i, X_Set, exp_q[0].x);
                end
`ifdef ALU_SET_ERR_EN
                asserts++;
                if (err !== exp_q[0].e) begin
                    fails++; $display("FAIL oob_err[%0d]: got %b want %b", i, err, exp_q[0].e);
                end
`endif
                void'(exp_q.pop_front());
            end
        end
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
    endtask

    // Reset lands while a result is pending and acc is nonzero.
    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1'b1, OP_ACC_OR, 6'b001100, 6'b000000);
        exp_q.push_back('{x: 6'b001100, e: 1'b0});
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b1 || acc_out !== 6'b001100) begin
            fails++; $display("FAIL rmid_pre: valid %b acc %b want 1 001100", out_valid, acc_out);
        end
        drive(1'b0, OP_CLR, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_valid: got %b want 0", out_valid);
        end
        asserts++;
        if (X_Set !== 6'b000000) begin
            fails++; $display("FAIL rmid_x: got %b want 000000", X_Set);
        end
        asserts++;
        if (acc_out !== 6'b000000) begin
            fails++; $display("FAIL rmid_acc: got %b want 000000", acc_out);
        end
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        drive(1'b1, OP_PASS_A, 6'b110011, 6'b000000);
        exp_q.push_back('{x: 6'b110011, e: 1'b0});
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || X_Set !== exp_q[0].x) begin
            fails++; $display("FAIL rmid_resume: got %b valid %b want 110011", X_Set, out_valid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        drive(1'b0, OP_CLR, '0, '0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_const();
        test_bitops();
        test_acc();
        test_stall();
        test_oob();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/alu_set_unit.md
Name: alu_set_unit

Overview:
- Parametrised, registered successor to the ALU constant-set block.
- Produces WIDTH-bit constants (all-zeros / all-ones), operand pass-through, single-bit set/clear/toggle, and a sticky OR-accumulator.
- Every selector code has a defined result; no latched outputs.
- Sits in the ALU datapath behind a valid/ready handshake with one output register stage.

Parameters:
- WIDTH, 6, operand/result width; legal range 2..32.
- IDX_W, $clog2(WIDTH), bit-index width taken from B_Set[IDX_W-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit accepts a request this cycle
- A_Set  input  WIDTH  operand A
- B_Set  input  WIDTH  operand B; low IDX_W bits are the bit index for bit ops
- sel  input  4  operation code
- out_valid  output  1  X_Set holds a result
- out_ready  input  1  consumer accepts the result
- X_Set  output  WIDTH  result
- acc_out  output  WIDTH  current accumulator value (continuous)

Behaviour:
- Opcodes:
  - 0000 CLR: all zeros.
  - 1111 SET: all ones.
  - 0001 PASS_A: A.
  - 0010 PASS_B: B.
  - 0011 BSET: A | (1<<idx).
  - 0100 BCLR: A & ~(1<<idx).
  - 0101 BTGL: A ^ (1<<idx).
  - 0110 ACC_OR: result = acc | A; acc <= acc | A.
  - 0111 ACC_RD_CLR: result = acc; acc <= 0.
  - All other codes are illegal (see Optional Feature).
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so full throughput with one result per cycle.
  - Result appears on X_Set with out_valid=1 on the cycle after accept (latency 1).
  - X_Set and out_valid hold stable while out_valid && !out_ready.
  - out_valid drops the cycle after out_ready if there is no new accept.
- Accumulator:
  - Updates only on accept of opcode 0110 or 0111.
  - ACC_OR followed by ACC_OR back-to-back: the second op sees the updated acc.
  - No forwarding hazard, because acc updates at the accept edge.
- Bit ops with idx >= WIDTH (e.g. WIDTH=6, idx 6 or 7): result = A unchanged; the op is flagged as illegal.
- Stalled consumer: a new request is not accepted; the accumulator is not modified by an unaccepted request.
- Reset (synchronous, has priority over everything, including mid-transfer):
  - out_valid=0, X_Set=0, acc=0.
  - in_ready=1 on the cycle after reset deasserts.
  - A pending result is discarded.
- X_Set is registered; acc_out is the registered accumulator.

Optional Feature:
- Macro: ALU_SET_ERR_EN.
- Defined:
  - Adds output port err (1 bit), registered alongside X_Set, reset 0.
  - err=1 with out_valid for an illegal opcode or an out-of-range bit index.
  - Illegal opcode: X_Set = previous X_Set value.
  - Out-of-range bit op: X_Set = A.
- Undefined:
  - No err port.
  - Illegal opcodes produce X_Set = 0.
  - Out-of-range bit ops still return A.
  - The handshake is identical in both builds.

Decomposition:
- Package alu_set_pkg:
  - Opcode localparams: OP_CLR, OP_PASS_A, OP_PASS_B, OP_BSET, OP_BCLR, OP_BTGL, OP_ACC_OR, OP_ACC_RD_CLR, OP_SET.
  - Shared ALU select width constant SEL_W=4.
- One sub-module: set_bit_mask.
  - Combinational; produces the one-hot WIDTH mask plus an idx_oob flag from the IDX_W index.
  - Reused by other ALU bit-manipulation blocks.

Test Plan (all WIDTH=6):
- Reset, then sel=0000 then sel=1111 back-to-back with out_ready=1 -> X_Set 000000 then 111111 on consecutive cycles; out_valid high for 2 cycles.
- A=101010, B idx=0: BSET -> 101011; BCLR with idx=1 -> 101000; BTGL with idx=5 -> 001010.
- ACC_OR with A=000011, then A=110000, then ACC_RD_CLR -> results 000011, 110011, 110011; acc_out=000000 afterwards.
- out_ready held low 3 cycles after accepting PASS_A with A=010101 -> X_Set stays 010101; in_ready=0; a concurrent ACC_OR request leaves acc unchanged until accepted.
- BSET with idx=7, A=000001 -> X_Set=000001; err=1 if ALU_SET_ERR_EN is defined. sel=1010 -> err=1 and X_Set held (enabled build) or X_Set=000000 (disabled build).
- Reset asserted while out_valid=1 and acc=001100 -> next cycle out_valid=0, X_Set=0, acc_out=0, in_ready=1.
